// File: rtl/writeback.sv
// writeback: FIFO-buffered retirement of ALU results; in_* enqueue, wr_* drive the GPR write port, eflags is the architectural flags register, busy means entries are pending
module writeback #(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] in_cntl,
  input  logic [4:0]  in_status,
  input  logic [31:0] in_result,
  input  logic [31:0] in_old,
  input  logic [2:0]  in_dest,
  input  logic [1:0]  in_width,
  input  logic        flush,
  output logic        wr_en,
  output logic [2:0]  wr_idx,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic [31:0] eflags,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]   data_q [DEPTH];
  logic [2:0]    idx_q  [DEPTH];
  logic [8:0]    meta_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [8:0]    head;
  logic [31:0]   merged;
  logic          enq, commit;
  logic          unused_cntl;
  assign unused_cntl = ^{in_cntl[10], in_cntl[8:0]};
  always_comb begin
    merged   = in_width == 2'd0 ? {in_old[31:8], in_result[7:0]} :
               in_width == 2'd1 ? {in_old[31:16], in_result[15:0]} : in_result;
    head     = meta_q[rd_ptr];
    busy     = count != '0;
    in_ready = count != FULL;
    wr_en    = busy & ~head[5];
    wr_idx   = idx_q[rd_ptr];
    wr_data  = data_q[rd_ptr];
    enq      = in_valid & in_ready & ~flush;
    commit   = busy & ~flush & (head[5] | wr_ready);
  end
  always_ff @(posedge clk)
    if (enq) begin
      data_q[wr_ptr] <= merged;
      idx_q[wr_ptr]  <= in_dest;
      meta_q[wr_ptr] <= {in_cntl[13], in_cntl[12], in_cntl[11], in_cntl[9], in_status};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      eflags <= EFLAGS_RESET;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count + (AW+1)'(enq) - (AW+1)'(commit);
      rd_ptr <= rd_ptr + AW'(commit);
      wr_ptr <= wr_ptr + AW'(enq);
      if (commit & ~head[6]) begin
        eflags[0]  <= head[4] & ~head[7];
        eflags[2]  <= head[3];
        eflags[6]  <= head[2];
        eflags[7]  <= head[1];
        eflags[11] <= head[0] & ~head[8];
      end
    end
endmodule
